// File: rtl/hazard_forward_unit_if.sv
// Decode-side bundle for the hazard/forwarding tracker: the issuing instruction's
// register usage in, stall and per-operand forward selects out.
interface hazard_forward_unit_if #(
    parameter int REG_AW     = 3,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 16
);
    localparam int FW = $clog2(PIPE_DEPTH + 1);

    logic                  issue_valid;
    logic [REG_AW-1:0]     src_a;
    logic                  src_a_use;
    logic [REG_AW-1:0]     src_b;
    logic                  src_b_use;
    logic [REG_AW-1:0]     dst;
    logic                  dst_wr;
    logic                  is_load;
    logic                  flush;

    logic                  stall;
    logic [FW-1:0]         fwd_a_sel;
    logic [FW-1:0]         fwd_b_sel;
    logic [PIPE_DEPTH-1:0] valid_vec;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output issue_valid, src_a, src_a_use, src_b, src_b_use, dst, dst_wr, is_load, flush,
        input  stall, fwd_a_sel, fwd_b_sel, valid_vec, stall_cnt
    );

    modport slave (
        input  issue_valid, src_a, src_a_use, src_b, src_b_use, dst, dst_wr, is_load, flush,
        output stall, fwd_a_sel, fwd_b_sel, valid_vec, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Forwarding/hazard tracker: shift table of the last PIPE_DEPTH issued instructions,
// youngest-match operand forwarding, load-use stall with bubble insertion and a stall counter.
module hfu_entry_cmp #(
    parameter int REG_AW = 3
) (
    input  logic              vld,
    input  logic              wr,
    input  logic [REG_AW-1:0] dst,
    input  logic [REG_AW-1:0] src_a,
    input  logic              src_a_use,
    input  logic [REG_AW-1:0] src_b,
    input  logic              src_b_use,
    output logic              hit_a,
    output logic              hit_b
);
    logic producer;

    assign producer = vld & wr;
    assign hit_a    = producer & src_a_use & (dst == src_a);
    assign hit_b    = producer & src_b_use & (dst == src_b);
endmodule

module hazard_forward_unit #(
    parameter int REG_AW     = 3,
    parameter int PIPE_DEPTH = 2,
    parameter int LOAD_LAT   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_forward_unit_if.slave  hif
);
    localparam int FW = $clog2(PIPE_DEPTH + 1);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] dst;
        logic              wr;
        logic              ld;
    } ent_t;

    // index i holds entry i+1, i.e. the instruction issued i+1 cycles ago
    ent_t [PIPE_DEPTH-1:0] ent_q, ent_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic [PIPE_DEPTH-1:0] hit_a, hit_b;
    logic [FW-1:0]         sel_a, sel_b;
    logic                  ld_a, ld_b;
    logic                  late_a, late_b;
    logic                  stall;
    logic                  accept;

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_ent
        hfu_entry_cmp #(.REG_AW(REG_AW)) u_cmp (
            .vld       (ent_q[g].vld),
            .wr        (ent_q[g].wr),
            .dst       (ent_q[g].dst),
            .src_a     (hif.src_a),
            .src_a_use (hif.src_a_use),
            .src_b     (hif.src_b),
            .src_b_use (hif.src_b_use),
            .hit_a     (hit_a[g]),
            .hit_b     (hit_b[g])
        );
    end

    // scan oldest to youngest so the youngest hit is the one left standing
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            if (hit_a[i]) begin
                sel_a = FW'(i + 1);
                ld_a  = ent_q[i].ld;
            end
            if (hit_b[i]) begin
                sel_b = FW'(i + 1);
                ld_b  = ent_q[i].ld;
            end
        end
    end

    assign late_a = ld_a & (int'(sel_a) < LOAD_LAT);
    assign late_b = ld_b & (int'(sel_b) < LOAD_LAT);
    assign stall  = hif.issue_valid & ~hif.flush & (late_a | late_b);
    assign accept = hif.issue_valid & ~stall & ~hif.flush;

    always_comb begin
        ent_d = '0;
        if (!hif.flush) begin
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                ent_d[i] = ent_q[i-1];
            end
            if (accept) begin
                ent_d[0].vld = 1'b1;
                ent_d[0].dst = hif.dst;
                ent_d[0].wr  = hif.dst_wr;
                ent_d[0].ld  = hif.is_load;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ent_q       <= ent_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            hif.valid_vec[i] = ent_q[i].vld;
        end
    end

    assign hif.stall     = stall;
    assign hif.fwd_a_sel = hif.issue_valid ? sel_a : '0;
    assign hif.fwd_b_sel = hif.issue_valid ? sel_b : '0;
    assign hif.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: forwarding, youngest-match, load-use stall, flush, reset and counter saturation.
module tb_hazard_forward_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   nst = 0;

    always #5 clk = ~clk;

    hazard_forward_unit_if #(.REG_AW(3), .PIPE_DEPTH(2), .CNT_W(16)) h0 ();
    hazard_forward_unit_if #(.REG_AW(3), .PIPE_DEPTH(2), .CNT_W(2))  h1 ();

    hazard_forward_unit #(.REG_AW(3), .PIPE_DEPTH(2), .LOAD_LAT(2), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .hif(h0)
    );
    hazard_forward_unit #(.REG_AW(3), .PIPE_DEPTH(2), .LOAD_LAT(2), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .hif(h1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drv(input logic iv, input logic [2:0] d, input logic dw, input logic ld,
                       input logic [2:0] sa, input logic sau, input logic [2:0] sb,
                       input logic sbu, input logic fl);
        h0.issue_valid = iv;
        h0.dst         = d;
        h0.dst_wr      = dw;
        h0.is_load     = ld;
        h0.src_a       = sa;
        h0.src_a_use   = sau;
        h0.src_b       = sb;
        h0.src_b_use   = sbu;
        h0.flush       = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        h1.issue_valid = 0; h1.dst = 0; h1.dst_wr = 0; h1.is_load = 0; h1.flush = 0;
        h1.src_a = 0; h1.src_a_use = 0; h1.src_b = 0; h1.src_b_use = 0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_stall", 32'(h0.stall), 0);
        chk("rst_fwd_a", 32'(h0.fwd_a_sel), 0);
        chk("rst_fwd_b", 32'(h0.fwd_b_sel), 0);
        chk("rst_valid", 32'(h0.valid_vec), 0);
        chk("rst_cnt", 32'(h0.stall_cnt), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // ADDI r3 then ST reading r3 on A
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("t1_issue_stall", 32'(h0.stall), 0);
        step();
        drv(1, 0, 0, 0, 3, 1, 1, 1, 0);
        chk("t1_fwd_a", 32'(h0.fwd_a_sel), 1);
        chk("t1_fwd_b", 32'(h0.fwd_b_sel), 0);
        chk("t1_stall", 32'(h0.stall), 0);
        chk("t1_valid", 32'(h0.valid_vec), 1);
        step();

        // one unrelated gap -> entry 2; second gap -> regfile
        drv(1, 0, 0, 0, 0, 1, 3, 1, 0);
        chk("t2_fwd_b2", 32'(h0.fwd_b_sel), 2);
        chk("t2_fwd_a", 32'(h0.fwd_a_sel), 0);
        chk("t2_valid", 32'(h0.valid_vec), 3);
        step();
        drv(1, 0, 0, 0, 0, 0, 3, 1, 0);
        chk("t2_fwd_b0", 32'(h0.fwd_b_sel), 0);
        step();

        // two live writers of r3: youngest wins
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
        step();
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
        step();
        drv(1, 0, 0, 0, 3, 1, 3, 1, 0);
        chk("t3_fwd_a", 32'(h0.fwd_a_sel), 1);
        chk("t3_fwd_b", 32'(h0.fwd_b_sel), 1);
        drv(0, 0, 0, 0, 3, 1, 3, 1, 0);
        chk("t3_noissue_a", 32'(h0.fwd_a_sel), 0);
        chk("t3_noissue_b", 32'(h0.fwd_b_sel), 0);
        step();
        drv(1, 0, 0, 0, 3, 1, 0, 0, 0);
        chk("t3_fwd_a_e2", 32'(h0.fwd_a_sel), 2);
        chk("t3_valid", 32'(h0.valid_vec), 2);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("t3_drain", 32'(h0.valid_vec), 0);

        // load-use: one stall cycle, then forward from entry 2
        drv(1, 5, 1, 1, 0, 0, 0, 0, 0);
        step();
        drv(1, 6, 1, 0, 5, 1, 0, 0, 0);
        chk("t4_stall", 32'(h0.stall), 1);
        chk("t4_sel_in_stall", 32'(h0.fwd_a_sel), 1);
        chk("t4_valid0", 32'(h0.valid_vec), 1);
        step();
        chk("t4_unstall", 32'(h0.stall), 0);
        chk("t4_fwd_a", 32'(h0.fwd_a_sel), 2);
        chk("t4_cnt", 32'(h0.stall_cnt), 1);
        chk("t4_valid1", 32'(h0.valid_vec), 2);
        step();
        chk("t4_cnt_hold", 32'(h0.stall_cnt), 1);
        chk("t4_valid2", 32'(h0.valid_vec), 1);

        // flush beats stall and clears table
        drv(1, 5, 1, 1, 0, 0, 0, 0, 0);
        step();
        drv(1, 6, 1, 0, 5, 1, 0, 0, 1);
        chk("t5_flush_stall", 32'(h0.stall), 0);
        step();
        drv(1, 6, 1, 0, 5, 1, 0, 0, 0);
        chk("t5_valid", 32'(h0.valid_vec), 0);
        chk("t5_stall", 32'(h0.stall), 0);
        chk("t5_fwd_a", 32'(h0.fwd_a_sel), 0);
        chk("t5_cnt", 32'(h0.stall_cnt), 1);
        step();

        // async reset in the middle of a stall
        drv(1, 5, 1, 1, 0, 0, 0, 0, 0);
        step();
        drv(1, 6, 1, 0, 5, 1, 0, 0, 0);
        chk("t6_pre_stall", 32'(h0.stall), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_stall", 32'(h0.stall), 0);
        chk("t6_rst_valid", 32'(h0.valid_vec), 0);
        chk("t6_rst_cnt", 32'(h0.stall_cnt), 0);
        chk("t6_rst_fwd_a", 32'(h0.fwd_a_sel), 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2-bit counter: LD r5 that also reads r5, re-presented every cycle
        h1.issue_valid = 1; h1.dst = 5; h1.dst_wr = 1; h1.is_load = 1;
        h1.src_a = 5; h1.src_a_use = 1;
        step();
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (h1.stall) nst++;
            step();
            if (c == 2) chk("sat_cnt_c2", 32'(h1.stall_cnt), 1);
            if (c == 6) chk("sat_cnt_c6", 32'(h1.stall_cnt), 3);
            if (c == 10) chk("sat_cnt_c10", 32'(h1.stall_cnt), 3);
        end
        chk("sat_nstalls", 32'(nst), 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
